nibble_assembler_4to1_16: RTL and testbench

//  Builds a 16-bit word from four 4-bit digits entered one at a time, most significant digit first.

---
 rtl/nibble_pkg.sv | 12 +
 rtl/nibble_assembler_4to1_16.sv | 110 +++++++++++
 tb/tb_nibble_assembler_4to1_16.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/nibble_pkg.sv
// Shared types and default sizing for the nibble assembler.
package nibble_pkg;

    localparam int unsigned DIG_W_DEF    = 4;
    localparam int unsigned N_DIGITS_DEF = 4;

    typedef enum logic {
        S_COLLECT = 1'b0,
        S_FULL    = 1'b1
    } asm_state_t;

endpackage

// File: rtl/nibble_assembler_4to1_16.sv
// Assembles N_DIGITS digits (MS digit first) into one word, handed off over valid/ready.
// Optional feature: define DIGIT_BACKSPACE_EN to add the del (backspace) input.
module nibble_assembler_4to1_16
    import nibble_pkg::*;
#(
    parameter int unsigned N_DIGITS = N_DIGITS_DEF,
    parameter int unsigned DIG_W    = DIG_W_DEF,
    localparam int unsigned WORD_W  = N_DIGITS * DIG_W,
    localparam int unsigned CNT_W   = $clog2(N_DIGITS + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic [DIG_W-1:0]  nibble_in,
    input  logic              nibble_valid,
    output logic              nibble_ready,
    output logic [WORD_W-1:0] word_out,
    output logic              word_valid,
    input  logic              word_ready,
    output logic [WORD_W-1:0] partial_word,
`ifdef DIGIT_BACKSPACE_EN
    input  logic              del,
`endif
    output logic [CNT_W-1:0]  digit_count
);

    asm_state_t        state, state_nxt;
    logic [WORD_W-1:0] shift_reg, shift_nxt;
    logic [WORD_W-1:0] word_reg, word_nxt;
    logic [CNT_W-1:0]  cnt_reg, cnt_nxt;
    logic              valid_reg, valid_nxt;
    logic              take;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_COLLECT;
            shift_reg <= '0;
            word_reg  <= '0;
            cnt_reg   <= '0;
            valid_reg <= 1'b0;
        end else begin
            state     <= state_nxt;
            shift_reg <= shift_nxt;
            word_reg  <= word_nxt;
            cnt_reg   <= cnt_nxt;
            valid_reg <= valid_nxt;
        end
    end

    // Next-state and datapath update; clear aborts the entry from any state
    always_comb begin
        state_nxt = state;
        shift_nxt = shift_reg;
        word_nxt  = word_reg;
        cnt_nxt   = cnt_reg;
        valid_nxt = valid_reg;
        take      = nibble_valid & nibble_ready;
        if (clear) begin
            state_nxt = S_COLLECT;
            shift_nxt = '0;
            cnt_nxt   = '0;
            valid_nxt = 1'b0;
        end else begin
            case (state)
                S_COLLECT: begin
`ifdef DIGIT_BACKSPACE_EN
                    if (del && cnt_reg != '0) begin
                        shift_nxt = shift_reg >> DIG_W;
                        cnt_nxt   = cnt_reg - CNT_W'(1);
                    end
`endif
                    // del blocks nibble_ready, so take and backspace never coincide
                    if (take) begin
                        shift_nxt = {shift_reg[WORD_W-DIG_W-1:0], nibble_in};
                        if (cnt_reg != CNT_W'(N_DIGITS))
                            cnt_nxt = cnt_reg + CNT_W'(1);
                        if (cnt_reg == CNT_W'(N_DIGITS - 1)) begin
                            word_nxt  = shift_nxt;
                            state_nxt = S_FULL;
                            valid_nxt = 1'b1;
                        end
                    end
                end
                S_FULL: begin
                    if (valid_reg && word_ready) begin
                        state_nxt = S_COLLECT;
                        shift_nxt = '0;
                        cnt_nxt   = '0;
                        valid_nxt = 1'b0;
                    end
                end
                default: state_nxt = S_COLLECT;
            endcase
        end
    end

    // Outputs
    always_comb begin
        nibble_ready = (state == S_COLLECT) & ~clear;
`ifdef DIGIT_BACKSPACE_EN
        nibble_ready = nibble_ready & ~del;
`endif
        word_out     = word_reg;
        word_valid   = valid_reg;
        partial_word = shift_reg;
        digit_count  = cnt_reg;
    end

endmodule

// File: tb/tb_nibble_assembler_4to1_16.sv
// Self-checking bench: directed scenarios plus random traffic against a digit-queue model.
module tb_nibble_assembler_4to1_16;

`ifdef DIGIT_BACKSPACE_EN
    localparam bit BS = 1'b1;
`else
    localparam bit BS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, clear, nibble_valid, nibble_ready, word_valid, word_ready, del;
    logic [3:0]  nibble_in;
    logic [15:0] word_out, partial_word;
    logic [2:0]  digit_count;

    int tests  = 0;
    int failed = 0;

    // Model: the digits currently held, whether a word is pending, the last completed word
    int          q[$];
    bit          mfull;
    logic [15:0] mword;

    always #5 clk = ~clk;

    nibble_assembler_4to1_16 dut (
        .clk          (clk),
        .reset        (reset),
        .clear        (clear),
        .nibble_in    (nibble_in),
        .nibble_valid (nibble_valid),
        .nibble_ready (nibble_ready),
        .word_out     (word_out),
        .word_valid   (word_valid),
        .word_ready   (word_ready),
        .partial_word (partial_word),
`ifdef DIGIT_BACKSPACE_EN
        .del          (del),
`endif
        .digit_count  (digit_count)
    );

    function automatic logic [15:0] qval();
        int r = 0;
        foreach (q[i]) r = r * 16 + q[i];
        return 16'(r);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic v, input logic [3:0] n, input logic clr,
                              input logic wr, input logic d, input logic rst);
        if (rst) begin
            q.delete(); mfull = 1'b0; mword = '0;
        end else if (clr) begin
            q.delete(); mfull = 1'b0;
        end else if (mfull) begin
            if (wr) begin mfull = 1'b0; q.delete(); end
        end else if (d && q.size() > 0) begin
            void'(q.pop_back());
        end else if (v && !d) begin
            q.push_back(int'(n));
            if (q.size() == 4) begin mfull = 1'b1; mword = qval(); end
        end
    endtask

    // One clock: drive, check ready before the edge, update model, check registers after
    task automatic cyc(input logic v, input logic [3:0] n, input logic clr,
                       input logic wr, input logic d, input logic rst);
        logic dm;
        dm           = d & BS;
        nibble_valid = v; nibble_in = n; clear = clr;
        word_ready   = wr; del = dm; reset = rst;
        #1;
        if (!rst) chk("nibble_ready", 32'(nibble_ready), 32'(!mfull && !clr && !dm));
        @(posedge clk);
        model_step(v, n, clr, wr, dm, rst);
        #1;
        chk("partial_word", 32'(partial_word), 32'(qval()));
        chk("digit_count",  32'(digit_count),  32'(q.size()));
        chk("word_valid",   32'(word_valid),   32'(mfull));
        chk("word_out",     32'(word_out),     32'(mword));
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Offer digit n until accepted, with word_ready held at wr; bounded
    task automatic push(input logic [3:0] n, input logic wr);
        int k = 0;
        while (mfull && k < 10) begin
            cyc(1'b1, n, 1'b0, wr, 1'b0, 1'b0);
            k++;
        end
        chk("push_bound", 32'(k < 10), 32'd1);
        cyc(1'b1, n, 1'b0, wr, 1'b0, 1'b0);
    endtask

    initial begin
        mfull = 1'b0; mword = '0;
        cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("reset_count", 32'(digit_count), 32'd0);
        chk("reset_valid", 32'(word_valid), 32'd0);

        // 1: A,B,C,D back to back, no downstream take
        cyc(1'b1, 4'hA, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t1_p1", 32'(partial_word), 32'h000A);
        cyc(1'b1, 4'hB, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t1_p2", 32'(partial_word), 32'h00AB);
        cyc(1'b1, 4'hC, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t1_p3", 32'(partial_word), 32'h0ABC);
        cyc(1'b1, 4'hD, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t1_word",  32'(word_out), 32'hABCD);
        chk("t1_valid", 32'(word_valid), 32'd1);
        chk("t1_count", 32'(digit_count), 32'd4);

        // 2: stall with a digit pending, then release
        for (int i = 0; i < 5; i++) cyc(1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t2_hold", 32'(word_out), 32'hABCD);
        cyc(1'b1, 4'h1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("t2_drop", 32'(word_valid), 32'd0);
        cyc(1'b1, 4'h1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("t2_take", 32'(partial_word), 32'h0001);

        // 3: clear mid-entry, then 1234
        cyc(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 4'h6, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 4'h7, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t3_clear", 32'(partial_word), 32'h0000);
        for (int i = 1; i <= 4; i++) cyc(1'b1, 4'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t3_word", 32'(word_out), 32'h1234);
        cyc(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);

        // 4: reset mid-entry, then F00F
        cyc(1'b1, 4'h7, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 4'h8, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 4'h9, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 4'h3, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t4_rst_word", 32'(word_out), 32'h0000);
        cyc(1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t4_word", 32'(word_out), 32'hF00F);
        cyc(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);

`ifdef DIGIT_BACKSPACE_EN
        // 5: backspace cases
        cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t5_del_empty", 32'(digit_count), 32'd0);
        cyc(1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t5_del", 32'(partial_word), 32'h0001);
        cyc(1'b1, 4'h9, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t5_del_vs_digit", 32'(digit_count), 32'd0);
        cyc(1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 4'h4, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t5_word", 32'(word_out), 32'h1345);
        cyc(1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0);
`endif

        // 6: back-to-back words with word_ready held high
        for (int i = 0; i < 4; i++) push(4'h1, 1'b1);
        chk("t6_w1",  32'(word_out), 32'h1111);
        chk("t6_v1",  32'(word_valid), 32'd1);
        for (int i = 0; i < 4; i++) push(4'h2, 1'b1);
        chk("t6_w2",  32'(word_out), 32'h2222);
        cyc(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("t6_v2_pulse", 32'(word_valid), 32'd0);

        // Random traffic against the model
        for (int i = 0; i < 800; i++) begin
            cyc(1'($urandom_range(3) != 0), 4'($urandom), 1'($urandom_range(19) == 0),
                1'($urandom_range(2) == 0), 1'($urandom_range(7) == 0),
                1'($urandom_range(59) == 0));
        end
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
